// File: rtl/custom_addsub_seq.sv
// Multi-cycle add/sub/accumulate unit behind a start/finish call handshake.
// The result is computed at accept time and released after LATENCY cycles.
module custom_addsub_seq #(
    parameter int               WIDTH    = 32,
    parameter int               LATENCY  = 3,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] arg_i,
    input  logic [WIDTH-1:0] arg_j,
    input  logic [1:0]       arg_mode,
    output logic             finish,
    output logic [WIDTH-1:0] return_val,
    output logic             overflow
);

    localparam int            CW     = 5;
    localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic             r_res_ovf;
    logic             r_finish;
    logic [WIDTH-1:0] r_return_val;
    logic             r_overflow;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_accept;

    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign w_sum     = arg_i + arg_j;
    assign w_diff    = arg_i - arg_j;
    assign w_acc_sum = r_acc + arg_i;
    assign w_accept  = start && (r_state != S_BUSY);

    // Result, overflow and next accumulator for the requested mode
    always_comb begin
        w_res     = {WIDTH{1'b0}};
        w_ovf     = 1'b0;
        w_acc_nxt = r_acc;
        case (arg_mode)
            2'b00: begin
                w_res = w_sum;
                w_ovf = add_ovf(arg_i, arg_j, w_sum);
            end
            2'b01: begin
                w_res = w_diff;
                w_ovf = sub_ovf(arg_i, arg_j, w_diff);
            end
            2'b10: begin
                w_res     = w_acc_sum;
                w_ovf     = add_ovf(r_acc, arg_i, w_acc_sum);
                w_acc_nxt = w_acc_sum;
            end
            2'b11: begin
                w_res     = r_acc;
                w_ovf     = 1'b0;
                w_acc_nxt = ACC_INIT;
            end
            default: begin
                w_res     = {WIDTH{1'b0}};
                w_ovf     = 1'b0;
                w_acc_nxt = r_acc;
            end
        endcase
    end

    // Call FSM, latency counter, accumulator and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= {CW{1'b0}};
            r_acc        <= ACC_INIT;
            r_res        <= {WIDTH{1'b0}};
            r_res_ovf    <= 1'b0;
            r_finish     <= 1'b0;
            r_return_val <= {WIDTH{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    // Counter is at least 1 here; reaching 1 releases the result
                    if (r_cnt <= 5'd1) begin
                        r_state      <= S_DONE;
                        r_cnt        <= {CW{1'b0}};
                        r_finish     <= 1'b1;
                        r_return_val <= r_res;
                        r_overflow   <= r_res_ovf;
                    end else begin
                        r_state  <= S_BUSY;
                        r_cnt    <= r_cnt - 5'd1;
                        r_finish <= 1'b0;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_acc     <= w_acc_nxt;
                        r_res     <= w_res;
                        r_res_ovf <= w_ovf;
                        if (LATENCY == 1) begin
                            r_state      <= S_DONE;
                            r_cnt        <= {CW{1'b0}};
                            r_finish     <= 1'b1;
                            r_return_val <= w_res;
                            r_overflow   <= w_ovf;
                        end else begin
                            r_state  <= S_BUSY;
                            r_cnt    <= LAT_M1;
                            r_finish <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_finish <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= {CW{1'b0}};
                    r_finish <= 1'b0;
                end
            endcase
        end
    end

    assign finish     = r_finish;
    assign return_val = r_return_val;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_custom_addsub_seq.sv
// Directed bench: a LATENCY=3 instance for the main call sequences and a
// LATENCY=1 instance (ACC_INIT=5) for back-to-back single-cycle calls.
module tb_custom_addsub_seq;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [31:0] ai_a, aj_a, ai_b, aj_b;
    logic [1:0]  am_a, am_b;
    logic        fin_a, fin_b;
    logic [31:0] rv_a, rv_b;
    logic        ov_a, ov_b;

    int checks   = 0;
    int failures = 0;

    custom_addsub_seq #(.WIDTH(32), .LATENCY(3), .ACC_INIT(32'h0)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .arg_i(ai_a), .arg_j(aj_a),
        .arg_mode(am_a), .finish(fin_a), .return_val(rv_a), .overflow(ov_a)
    );

    custom_addsub_seq #(.WIDTH(32), .LATENCY(1), .ACC_INIT(32'h5)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .arg_i(ai_b), .arg_j(aj_b),
        .arg_mode(am_b), .finish(fin_b), .return_val(rv_b), .overflow(ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one call on the LATENCY=3 unit; returns in its finish cycle (T+3).
    task automatic call3(input string tag, input logic [1:0] mode, input logic [31:0] i,
                         input logic [31:0] j, input logic [31:0] exp_rv, input logic exp_ov);
        start_a = 1'b1; am_a = mode; ai_a = i; aj_a = j;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start_a = 1'b0;
            ai_a = 32'hDEAD_BEEF; aj_a = 32'h1234_5678;
            if (c < 3) chk({tag, "_nofin"}, {63'd0, fin_a}, 64'd0);
        end
        chk({tag, "_fin"}, {63'd0, fin_a}, 64'd1);
        chk({tag, "_rv"}, {32'd0, rv_a}, {32'd0, exp_rv});
        chk({tag, "_ov"}, {63'd0, ov_a}, {63'd0, exp_ov});
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; ai_a = 32'd0; aj_a = 32'd0; am_a = 2'b00;
        start_b = 1'b0; ai_b = 32'd0; aj_b = 32'd0; am_b = 2'b00;
        repeat (3) tick();
        chk("rst_fin", {63'd0, fin_a}, 64'd0);
        chk("rst_rv", {32'd0, rv_a}, 64'd0);
        chk("rst_ov", {63'd0, ov_a}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic add, then result held after the finish pulse
        call3("add5_7", 2'b00, 32'd5, 32'd7, 32'd12, 1'b0);
        tick();
        chk("add_hold_fin", {63'd0, fin_a}, 64'd0);
        chk("add_hold_rv", {32'd0, rv_a}, 64'd12);

        // Signed overflow boundaries, second call issued in the DONE cycle
        call3("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
        call3("sub_ovf", 2'b01, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
        tick();

        // Accumulate chain with read-and-clear
        call3("acc10", 2'b10, 32'd10, 32'd0, 32'd10, 1'b0);
        call3("acc20", 2'b10, 32'd20, 32'd0, 32'd30, 1'b0);
        call3("acc30", 2'b10, 32'd30, 32'd0, 32'd60, 1'b0);
        call3("rdclr", 2'b11, 32'd0, 32'd0, 32'd60, 1'b0);
        call3("acc1", 2'b10, 32'd1, 32'd0, 32'd1, 1'b0);
        tick();

        // Starts during BUSY must be ignored (accumulator stays at 1)
        start_a = 1'b1; am_a = 2'b00; ai_a = 32'd100; aj_a = 32'd200;
        tick();
        start_a = 1'b1; am_a = 2'b10; ai_a = 32'd1000; aj_a = 32'd1;
        chk("busy_t1_fin", {63'd0, fin_a}, 64'd0);
        tick();
        chk("busy_t2_fin", {63'd0, fin_a}, 64'd0);
        tick();
        start_a = 1'b0;
        chk("busy_t3_fin", {63'd0, fin_a}, 64'd1);
        chk("busy_t3_rv", {32'd0, rv_a}, 64'd300);
        tick();
        chk("busy_t4_fin", {63'd0, fin_a}, 64'd0);
        chk("busy_t4_rv", {32'd0, rv_a}, 64'd300);
        call3("busy_acc", 2'b11, 32'd0, 32'd0, 32'd1, 1'b0);
        tick();

        // Reset in the middle of an accumulate call
        start_a = 1'b1; am_a = 2'b10; ai_a = 32'd50; aj_a = 32'd0;
        tick();
        start_a = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rv", {32'd0, rv_a}, 64'd0);
        chk("midrst_fin", {63'd0, fin_a}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("midrst_nofin", {63'd0, fin_a}, 64'd0);
        end
        call3("midrst_rdclr", 2'b11, 32'd0, 32'd0, 32'd0, 1'b0);

        // Accumulator overflow flag, then read-and-clear reports no overflow
        call3("acc_max", 2'b10, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 1'b0);
        call3("acc_ovf", 2'b10, 32'd1, 32'd0, 32'h8000_0000, 1'b1);
        call3("acc_rdclr", 2'b11, 32'd0, 32'd0, 32'h8000_0000, 1'b0);
        tick();

        // LATENCY=1: a call every cycle, each result one cycle later
        for (int k = 1; k <= 5; k++) begin
            start_b = 1'b1; am_b = 2'b00; ai_b = k; aj_b = k;
            tick();
            chk("lat1_fin", {63'd0, fin_b}, 64'd1);
            chk("lat1_rv", {32'd0, rv_b}, 2 * k);
        end
        start_b = 1'b0;
        tick();
        chk("lat1_idle_fin", {63'd0, fin_b}, 64'd0);
        chk("lat1_idle_rv", {32'd0, rv_b}, 64'd10);
        start_b = 1'b1; am_b = 2'b11;
        tick();
        start_b = 1'b0;
        chk("lat1_init_fin", {63'd0, fin_b}, 64'd1);
        chk("lat1_init_rv", {32'd0, rv_b}, 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
